// File: rtl/fft_frame_loader.sv
// Snapshots the N-sample shift-register window every N enables and streams it
// out over a valid/ready handshake. Define FFT_LOADER_BITREV_EN for radix-2 DIT order.
module fft_frame_loader #(
    parameter int N     = 16,
    parameter int W     = 8,
    parameter int LOG2N = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N*W-1:0]   win_in,
    output logic [W-1:0]     o_data,
    output logic [LOG2N-1:0] o_idx,
    output logic             o_valid,
    input  logic             o_ready,
    output logic             o_last,
    output logic             overrun
);

    // state  | meaning
    // IDLE   | waiting for a frame_done; pending means capture on the next edge
    // STREAM | presenting frame samples, index i advances on each transfer
    typedef enum logic {IDLE, STREAM} state_t;

    state_t           state, state_nx;
    logic [LOG2N-1:0] cnt, i, i_nx, src;
    logic             pending, pending_nx, overrun_nx;
    logic             frame_done, xfer, capture;
    logic [W-1:0]     frame [N];

    function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
        logic [LOG2N-1:0] r;
        for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
        return r;
    endfunction

    assign frame_done = en && (cnt == LOG2N'(N-1));
    assign xfer       = (state == STREAM) && o_ready;

`ifdef FFT_LOADER_BITREV_EN
    assign src = bitrev(i);
`else
    assign src = i;
`endif

    always_comb begin
        state_nx   = state;
        i_nx       = i;
        pending_nx = pending;
        overrun_nx = overrun;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (pending) begin
                    capture    = 1'b1;
                    pending_nx = 1'b0;
                    i_nx       = '0;
                    state_nx   = STREAM;
                end else if (frame_done) begin
                    pending_nx = 1'b1;
                end
            end
            STREAM: begin
                // a frame completing while we still hold the previous one is lost
                if (frame_done) overrun_nx = 1'b1;
                if (xfer) begin
                    if (i == LOG2N'(N-1)) state_nx = IDLE;
                    else                  i_nx     = i + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            i       <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nx;
            i       <= i_nx;
            pending <= pending_nx;
            overrun <= overrun_nx;
            if (en) cnt <= cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N; k++) frame[k] <= '0;
        end else if (capture) begin
            for (int k = 0; k < N; k++) frame[k] <= win_in[k*W +: W];
        end
    end

    // outputs are zeroed outside STREAM so idle values match reset values
    assign o_valid = (state == STREAM);
    assign o_idx   = o_valid ? i : '0;
    assign o_data  = o_valid ? frame[src] : '0;
    assign o_last  = o_valid && (i == LOG2N'(N-1));

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a queue-based frame model;
// honours FFT_LOADER_BITREV_EN to pick the expected sample order.
module tb_fft_frame_loader;
    localparam int N = 16, W = 8, LOG2N = 4;

    logic             clk = 1'b0, rst, en, o_ready;
    logic [N*W-1:0]   win_in;
    logic [W-1:0]     o_data;
    logic [LOG2N-1:0] o_idx;
    logic             o_valid, o_last, overrun;

    fft_frame_loader #(.N(N), .W(W), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst), .en(en), .win_in(win_in),
        .o_data(o_data), .o_idx(o_idx), .o_valid(o_valid),
        .o_ready(o_ready), .o_last(o_last), .overrun(overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [W-1:0] d; logic [LOG2N-1:0] idx; } exp_t;

    logic [W-1:0] win [N];
    exp_t q[$];
    int   m_cnt, total, bad;
    bit   m_pend, m_ovr;

    always_comb begin
        win_in = '0;
        for (int k = 0; k < N; k++) win_in[k*W +: W] = win[k];
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int srcf(input int i);
        int r;
`ifdef FFT_LOADER_BITREV_EN
        r = 0;
        for (int b = 0; b < LOG2N; b++) r = r * 2 + ((i >> b) & 1);
`else
        r = i;
`endif
        return r;
    endfunction

    // model of one rising edge: the loader is busy while the queue is non-empty
    task automatic model_edge(input bit e, input bit r);
        bit fd;
        fd = e && (m_cnt == N - 1);
        if (q.size() > 0) begin
            if (fd) m_ovr = 1;
            if (r) void'(q.pop_front());
        end else if (m_pend) begin
            for (int i = 0; i < N; i++) q.push_back({win[srcf(i)], LOG2N'(i)});
            m_pend = 0;
        end else if (fd) begin
            m_pend = 1;
        end
        if (e) m_cnt = (m_cnt + 1) % N;
    endtask

    task automatic check_outputs();
        chk("valid", 32'(o_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            chk("data", 32'(o_data), 32'(q[0].d));
            chk("idx",  32'(o_idx),  32'(q[0].idx));
            chk("last", 32'(o_last), 32'(q[0].idx == LOG2N'(N - 1)));
        end
        chk("overrun", 32'(overrun), 32'(m_ovr));
    endtask

    // one clock: inputs applied at negedge, shift register updates on the edge
    task automatic cycle(input bit e, input bit r, input logic [W-1:0] s);
        en = e;
        o_ready = r;
        model_edge(e, r);
        @(posedge clk);
        @(negedge clk);
        if (e) begin
            for (int k = 0; k < N - 1; k++) win[k] = win[k + 1];
            win[N - 1] = s;
        end
        check_outputs();
    endtask

    task automatic fill_random(input bit r);
        for (int k = 0; k < N; k++) cycle(1'b1, r, W'($urandom_range(0, 255)));
    endtask

    task automatic drain(input int stall_at);
        int stalls, xfers;
        bit r;
        stalls = 0;
        xfers  = 0;
        for (int k = 0; k < 80 && (q.size() > 0 || m_pend); k++) begin
            r = 1'b1;
            if (stall_at >= 0 && stalls < 3 && q.size() > 0 && q[0].idx == LOG2N'(stall_at)) begin
                r = 1'b0;
                stalls++;
            end
            if (o_valid && r) xfers++;
            cycle(1'b0, r, '0);
        end
        chk("xfer_count", 32'(xfers), 32'(N));
    endtask

    initial begin
        total = 0; bad = 0; m_cnt = 0; m_pend = 0; m_ovr = 0;
        rst = 1'b1; en = 1'b0; o_ready = 1'b0;
        for (int k = 0; k < N; k++) win[k] = W'(k + 1);
        @(negedge clk);
        chk("rst_valid",   32'(o_valid), 0);
        chk("rst_last",    32'(o_last),  0);
        chk("rst_idx",     32'(o_idx),   0);
        chk("rst_data",    32'(o_data),  0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;

        // window ends up as slot k = k+1; stall 3 cycles at i=5
        for (int k = 0; k < N; k++) cycle(1'b1, 1'b1, W'(k + 1));
        drain(5);

        // overrun: second frame completes while the first is still held
        fill_random(1'b1);
        fill_random(1'b0);
        drain(-1);
        fill_random(1'b1);
        drain(-1);

        // reset in the middle of a frame
        fill_random(1'b1);
        for (int k = 0; k < 40 && !(q.size() > 0 && q[0].idx == 4'd7); k++) cycle(1'b0, 1'b1, '0);
        chk("at_idx7", 32'(o_idx), 7);
        en = 1'b0;
        rst = 1'b1;
        #1;
        chk("arst_valid",   32'(o_valid), 0);
        chk("arst_last",    32'(o_last),  0);
        chk("arst_overrun", 32'(overrun), 0);
        q.delete();
        m_cnt = 0; m_pend = 0; m_ovr = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        fill_random(1'b1);
        drain(-1);

        // continuous enable with a ready consumer
        for (int k = 0; k < 100; k++) cycle(1'b1, 1'b1, W'($urandom_range(0, 255)));

        // random traffic
        for (int k = 0; k < 3000; k++)
            cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), W'($urandom_range(0, 255)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
